// File: rtl/fp_exp_pkg.sv
// fp_exp_pkg: shared op encoding and
// signed exponent limit helpers.
package fp_exp_pkg;

  typedef enum logic [1:0] {
    OP_ONESHOT = 2'd0,
    OP_LOAD    = 2'd1,
    OP_ACCUM   = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  function automatic logic signed [32:0]
    exp_max(input int w);
    return (33'sd1 <<< (w - 1)) - 33'sd1;
  endfunction

  function automatic logic signed [32:0]
    exp_min(input int w);
    return -(33'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fp_exp_sat_add.sv
// fp_exp_sat_add: combinational saturating
// signed add, a + b -> sum with ovf/unf.
module fp_exp_sat_add
  import fp_exp_pkg::*;
#(
  parameter int EXP_W = 8
) (
  input  logic [EXP_W-1:0] a,
  input  logic [EXP_W-1:0] b,
  output logic [EXP_W-1:0] sum,
  output logic             ovf,
  output logic             unf
);

  localparam logic [EXP_W-1:0] MAX_V =
    EXP_W'(exp_max(EXP_W));
  localparam logic [EXP_W-1:0] MIN_V =
    EXP_W'(exp_min(EXP_W));

  logic [EXP_W:0] raw;

  always_comb begin
    raw = {a[EXP_W-1], a} + {b[EXP_W-1], b};
    ovf = ~raw[EXP_W] & raw[EXP_W-1];
    unf = raw[EXP_W] & ~raw[EXP_W-1];
    sum = raw[EXP_W-1:0];
    unique case (1'b1)
      ovf:     sum = MAX_V;
      unf:     sum = MIN_V;
      default: ;
    endcase
  end

endmodule

// File: rtl/fp_exp_accumulator.sv
// fp_exp_accumulator: registered saturating
// exponent adder/accumulator, valid/ready.
module fp_exp_accumulator
  import fp_exp_pkg::*;
#(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [EXP_W-1:0] change,
  input  logic             clr_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic             ovf,
  output logic             unf,
  output logic             sticky_ovf,
  output logic             sticky_unf
);

  op_e op_w;
  logic is_load;
  logic is_accum;
  logic accept;

  logic [EXP_W-1:0] acc_q, acc_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic vld_q, vld_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic sov_q, sov_d;
  logic sunf_q, sunf_d;

  logic [EXP_W-1:0] a_sel;
  logic [EXP_W-1:0] res;
  logic res_ovf;
  logic res_unf;

  assign op_w     = op_e'(op);
  assign is_load  = (op_w == OP_LOAD);
  assign is_accum = (op_w == OP_ACCUM);
  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign a_sel    = is_accum ? acc_q : in_exp;

  fp_exp_sat_add #(
    .EXP_W(EXP_W)
  ) u_add (
    .a  (a_sel),
    .b  (change),
    .sum(res),
    .ovf(res_ovf),
    .unf(res_unf)
  );

  always_comb begin
    acc_d  = acc_q;
    exp_d  = exp_q;
    vld_d  = vld_q && !out_ready;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    sov_d  = clr_sticky ? 1'b0 : sov_q;
    sunf_d = clr_sticky ? 1'b0 : sunf_q;
    if (accept) begin
      vld_d = 1'b1;
      unique case (1'b1)
        is_load: begin
          exp_d = in_exp;
          ovf_d = 1'b0;
          unf_d = 1'b0;
          acc_d = in_exp;
        end
        is_accum: begin
          exp_d = res;
          ovf_d = res_ovf;
          unf_d = res_unf;
          acc_d = res;
        end
        default: begin
          exp_d = res;
          ovf_d = res_ovf;
          unf_d = res_unf;
        end
      endcase
      // a set in the same cycle beats a clear
      if (ovf_d) sov_d = 1'b1;
      if (unf_d) sunf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      exp_q  <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      sov_q  <= 1'b0;
      sunf_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      exp_q  <= exp_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      sov_q  <= sov_d;
      sunf_q <= sunf_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_exp    = exp_q;
  assign ovf        = ovf_q;
  assign unf        = unf_q;
  assign sticky_ovf = sov_q;
  assign sticky_unf = sunf_q;

endmodule

// File: tb/tb_fp_exp_accumulator.sv
// tb_fp_exp_accumulator: directed vector
// table plus corner-case sequences.
module tb_fp_exp_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [7:0] in_exp;
  logic [7:0] change;
  logic       clr_sticky;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_exp;
  logic       ovf;
  logic       unf;
  logic       sticky_ovf;
  logic       sticky_unf;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] in_exp;
    logic [7:0] change;
    logic       clr;
    logic [7:0] e_exp;
    logic       e_ovf;
    logic       e_unf;
    logic       e_sov;
    logic       e_sunf;
  } vec_t;

  vec_t vecs[10];

  fp_exp_accumulator #(
    .EXP_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_exp    (in_exp),
    .change    (change),
    .clr_sticky(clr_sticky),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_exp   (out_exp),
    .ovf       (ovf),
    .unf       (unf),
    .sticky_ovf(sticky_ovf),
    .sticky_unf(sticky_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(
    input logic [1:0] o,
    input logic [7:0] e,
    input logic [7:0] c,
    input logic       clr
  );
    in_valid   = 1'b1;
    op         = o;
    in_exp     = e;
    change     = c;
    clr_sticky = clr;
  endtask

  task automatic chk_res(
    input string tag,
    input vec_t v
  );
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, " out_exp"}, 32'(out_exp), 32'(v.e_exp));
    chk({tag, " ovf"}, 32'(ovf), 32'(v.e_ovf));
    chk({tag, " unf"}, 32'(unf), 32'(v.e_unf));
    chk({tag, " sticky_ovf"},
        32'(sticky_ovf), 32'(v.e_sov));
    chk({tag, " sticky_unf"},
        32'(sticky_unf), 32'(v.e_sunf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;

    // op, in_exp, change, clr, exp, ovf, unf, sov, sunf
    vecs[0] = '{2'd0, 8'd100, 8'd27, 1'b0,
                8'd127, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'd0, 8'd100, 8'd28, 1'b0,
                8'd127, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2'd0, 8'(-100), 8'(-28), 1'b0,
                8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{2'd0, 8'(-100), 8'(-29), 1'b0,
                8'h80, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{2'd0, 8'd127, 8'(-128), 1'b0,
                8'hFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{2'd3, 8'd5, 8'd3, 1'b0,
                8'd8, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{2'd1, 8'd120, 8'd99, 1'b1,
                8'd120, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'd2, 8'd0, 8'd5, 1'b0,
                8'd125, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{2'd2, 8'd0, 8'd5, 1'b0,
                8'd127, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{2'd2, 8'd0, 8'(-10), 1'b0,
                8'd117, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    op         = 2'd0;
    in_exp     = 8'd0;
    change     = 8'd0;
    clr_sticky = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_exp", 32'(out_exp), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    chk("rst unf", 32'(unf), 32'd0);
    chk("rst sticky_ovf", 32'(sticky_ovf), 32'd0);
    chk("rst sticky_unf", 32'(sticky_unf), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].in_exp,
            vecs[i].change, vecs[i].clr);
      @(posedge clk);
      #1;
      chk_res($sformatf("vec%0d", i), vecs[i]);
    end

    // backpressure: acc=117 -> ACCUM +3 -> 120
    @(negedge clk);
    drive(2'd2, 8'd0, 8'd3, 1'b0);
    @(posedge clk);
    #1;
    chk("bp first", 32'(out_exp), 32'd120);
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'd2, 8'd0, 8'd3, 1'b0);
    #1;
    chk("bp in_ready low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp hold exp", 32'(out_exp), 32'd120);
      chk("bp hold vld", 32'(out_valid), 32'd1);
      chk("bp hold rdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp in_ready rise", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bp release exp", 32'(out_exp), 32'd123);
    chk("bp release vld", 32'(out_valid), 32'd1);
    @(negedge clk);
    drive(2'd2, 8'd0, 8'(-6), 1'b0);
    @(posedge clk);
    #1;
    chk("bp back exp", 32'(out_exp), 32'd117);

    // clear and underflow set in one cycle
    @(negedge clk);
    drive(2'd0, 8'(-100), 8'(-29), 1'b1);
    @(posedge clk);
    #1;
    v = '{2'd0, 8'd0, 8'd0, 1'b0,
          8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    chk_res("sticky", v);

    // reset mid-stream with out_valid=1
    @(negedge clk);
    in_valid   = 1'b0;
    clr_sticky = 1'b0;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst out_valid", 32'(out_valid), 32'd0);
    chk("mrst out_exp", 32'(out_exp), 32'd0);
    chk("mrst ovf", 32'(ovf), 32'd0);
    chk("mrst unf", 32'(unf), 32'd0);
    chk("mrst sticky_ovf", 32'(sticky_ovf), 32'd0);
    chk("mrst sticky_unf", 32'(sticky_unf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'd2, 8'd0, 8'd3, 1'b0);
    @(posedge clk);
    #1;
    v = '{2'd2, 8'd0, 8'd0, 1'b0,
          8'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    chk_res("post rst", v);

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain out_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
